// File: rtl/elapsed_timer.sv
// Stopwatch that counts prescaled ticks between Start and Stop and holds the result.
// Elapsed saturates at MAX_TICKS; one more tick cuts the run off and sets Overflow.
module elapsed_timer #(
    parameter int TICK_CYCLES = 50000,
    parameter int MAX_TICKS   = 65535,
    localparam int W          = $clog2(MAX_TICKS + 1)
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Stop,
    input  logic         Clear,
    output logic [W-1:0] Elapsed,
    output logic         Running,
    output logic         Done,
    output logic         Overflow
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [W-1:0]  MAX_VAL   = W'(MAX_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        r_state, w_stateNext;
    logic [PW-1:0] r_prescale, w_prescaleNext;
    logic [W-1:0]  r_elapsed, w_elapsedNext;
    logic          r_overflow, w_overflowNext;
    logic          r_done, w_doneNext;
    logic          r_running;
    logic          w_tick;

    assign w_tick = (r_prescale == TICK_LAST);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_prescale <= '0;
            r_elapsed  <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_prescale <= w_prescaleNext;
            r_elapsed  <= w_elapsedNext;
            r_overflow <= w_overflowNext;
            r_done     <= w_doneNext;
            r_running  <= (w_stateNext == RUN);
        end
    end

    // Priority Clear > Start > Stop; a Stop landing on a tick discards that tick.
    always_comb begin
        w_stateNext    = r_state;
        w_prescaleNext = r_prescale;
        w_elapsedNext  = r_elapsed;
        w_overflowNext = r_overflow;
        w_doneNext     = 1'b0;
        if (Clear) begin
            w_stateNext    = IDLE;
            w_prescaleNext = '0;
            w_elapsedNext  = '0;
            w_overflowNext = 1'b0;
        end else if (Start) begin
            w_stateNext    = RUN;
            w_prescaleNext = '0;
            w_elapsedNext  = '0;
            w_overflowNext = 1'b0;
        end else if (r_state == RUN) begin
            w_prescaleNext = w_tick ? '0 : r_prescale + PW'(1);
            if (Stop) begin
                w_stateNext = HOLD;
                w_doneNext  = 1'b1;
            end else if (w_tick) begin
                if (r_elapsed == MAX_VAL) begin
                    w_overflowNext = 1'b1;
                    w_stateNext    = HOLD;
                    w_doneNext     = 1'b1;
                end else begin
                    w_elapsedNext = r_elapsed + W'(1);
                end
            end
        end
    end

    assign Elapsed  = r_elapsed;
    assign Running  = r_running;
    assign Done     = r_done;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_elapsed_timer.sv
// Directed bench for elapsed_timer with TICK_CYCLES=4, MAX_TICKS=5.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_elapsed_timer;

    localparam int TC = 4;
    localparam int MT = 5;
    localparam int W  = 3;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         Start = 1'b0;
    logic         Stop = 1'b0;
    logic         Clear = 1'b0;
    logic [W-1:0] Elapsed;
    logic         Running;
    logic         Done;
    logic         Overflow;

    int total = 0;
    int bad = 0;

    elapsed_timer #(.TICK_CYCLES(TC), .MAX_TICKS(MT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stop(Stop), .Clear(Clear),
        .Elapsed(Elapsed), .Running(Running), .Done(Done), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Pulses Start through one edge (edge 0); returns just after edge 0.
    task automatic start_run();
        Start = 1'b1;
        cyc(1);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({Elapsed, Running, Done, Overflow} !== 6'b0) begin
            bad++;
            $display("FAIL reset_initial: got %b expected 000000", {Elapsed, Running, Done, Overflow});
        end
        #3 Reset_n = 1'b1;
        cyc(2);
        start_run();
        cyc(9);
        total++;
        if (Elapsed !== 3'd2 || Running !== 1'b1) begin
            bad++;
            $display("FAIL reset_prerun: got el=%0d run=%b expected el=2 run=1", Elapsed, Running);
        end
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if ({Elapsed, Running, Done, Overflow} !== 6'b0) begin
            bad++;
            $display("FAIL reset_async: got %b expected 000000", {Elapsed, Running, Done, Overflow});
        end
        #2 Reset_n = 1'b1;
        cyc(6);
        total++;
        if ({Elapsed, Running, Done, Overflow} !== 6'b0) begin
            bad++;
            $display("FAIL reset_idle_after: got %b expected 000000", {Elapsed, Running, Done, Overflow});
        end
    endtask

    task automatic test_basic();
        start_run();
        total++;
        if (Running !== 1'b1 || Elapsed !== 3'd0) begin
            bad++;
            $display("FAIL basic_start: got run=%b el=%0d expected run=1 el=0", Running, Elapsed);
        end
        cyc(3);
        total++;
        if (Elapsed !== 3'd0) begin
            bad++;
            $display("FAIL basic_edge3: got %0d expected 0", Elapsed);
        end
        cyc(1);
        total++;
        if (Elapsed !== 3'd1) begin
            bad++;
            $display("FAIL basic_edge4: got %0d expected 1", Elapsed);
        end
        cyc(4);
        total++;
        if (Elapsed !== 3'd2) begin
            bad++;
            $display("FAIL basic_edge8: got %0d expected 2", Elapsed);
        end
        cyc(1);
        Stop = 1'b1;
        cyc(1);
        Stop = 1'b0;
        total++;
        if (Running !== 1'b0 || Done !== 1'b1 || Elapsed !== 3'd2) begin
            bad++;
            $display("FAIL basic_stop: got run=%b done=%b el=%0d expected run=0 done=1 el=2", Running, Done, Elapsed);
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            total++;
            if (Elapsed !== 3'd2 || Done !== 1'b0 || Running !== 1'b0) begin
                bad++;
                $display("FAIL basic_hold[%0d]: got el=%0d done=%b run=%b expected el=2 done=0 run=0", i, Elapsed, Done, Running);
            end
        end
    endtask

    task automatic test_stop_on_tick();
        start_run();
        cyc(7);
        Stop = 1'b1;
        cyc(1);
        total++;
        if (Elapsed !== 3'd1 || Done !== 1'b1 || Overflow !== 1'b0 || Running !== 1'b0) begin
            bad++;
            $display("FAIL stoptick: got el=%0d done=%b ovf=%b run=%b expected el=1 done=1 ovf=0 run=0", Elapsed, Done, Overflow, Running);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            total++;
            if (Done !== 1'b0 || Elapsed !== 3'd1) begin
                bad++;
                $display("FAIL stoptick_held[%0d]: got done=%b el=%0d expected done=0 el=1", i, Done, Elapsed);
            end
        end
        Stop = 1'b0;
    endtask

    task automatic test_overflow();
        start_run();
        cyc(20);
        total++;
        if (Elapsed !== 3'd5 || Overflow !== 1'b0 || Running !== 1'b1) begin
            bad++;
            $display("FAIL ovf_edge20: got el=%0d ovf=%b run=%b expected el=5 ovf=0 run=1", Elapsed, Overflow, Running);
        end
        cyc(3);
        total++;
        if (Overflow !== 1'b0 || Done !== 1'b0 || Running !== 1'b1) begin
            bad++;
            $display("FAIL ovf_edge23: got ovf=%b done=%b run=%b expected ovf=0 done=0 run=1", Overflow, Done, Running);
        end
        cyc(1);
        total++;
        if (Overflow !== 1'b1 || Done !== 1'b1 || Running !== 1'b0 || Elapsed !== 3'd5) begin
            bad++;
            $display("FAIL ovf_edge24: got ovf=%b done=%b run=%b el=%0d expected ovf=1 done=1 run=0 el=5", Overflow, Done, Running, Elapsed);
        end
        cyc(1);
        total++;
        if (Done !== 1'b0) begin
            bad++;
            $display("FAIL ovf_done_pulse: got %b expected 0", Done);
        end
        Stop = 1'b1;
        cyc(1);
        Stop = 1'b0;
        cyc(1);
        total++;
        if (Done !== 1'b0 || Overflow !== 1'b1 || Elapsed !== 3'd5 || Running !== 1'b0) begin
            bad++;
            $display("FAIL ovf_late_stop: got done=%b ovf=%b el=%0d run=%b expected done=0 ovf=1 el=5 run=0", Done, Overflow, Elapsed, Running);
        end
    endtask

    task automatic test_clear();
        Clear = 1'b1;
        cyc(1);
        Clear = 1'b0;
        total++;
        if ({Elapsed, Running, Done, Overflow} !== 6'b0) begin
            bad++;
            $display("FAIL clear_hold: got %b expected 000000", {Elapsed, Running, Done, Overflow});
        end
        cyc(6);
        total++;
        if ({Elapsed, Running, Done, Overflow} !== 6'b0) begin
            bad++;
            $display("FAIL clear_idle: got %b expected 000000", {Elapsed, Running, Done, Overflow});
        end
        start_run();
        cyc(5);
        Clear = 1'b1;
        Start = 1'b1;
        cyc(1);
        Clear = 1'b0;
        Start = 1'b0;
        total++;
        if (Running !== 1'b0 || Elapsed !== 3'd0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL clear_start: got run=%b el=%0d done=%b expected run=0 el=0 done=0", Running, Elapsed, Done);
        end
        cyc(8);
        total++;
        if (Running !== 1'b0 || Elapsed !== 3'd0) begin
            bad++;
            $display("FAIL clear_start_idle: got run=%b el=%0d expected run=0 el=0", Running, Elapsed);
        end
    endtask

    task automatic test_back_to_back();
        start_run();
        cyc(12);
        total++;
        if (Elapsed !== 3'd3) begin
            bad++;
            $display("FAIL restart_pre: got %0d expected 3", Elapsed);
        end
        start_run();
        total++;
        if (Elapsed !== 3'd0 || Done !== 1'b0 || Running !== 1'b1) begin
            bad++;
            $display("FAIL restart_edge13: got el=%0d done=%b run=%b expected el=0 done=0 run=1", Elapsed, Done, Running);
        end
        cyc(3);
        total++;
        if (Elapsed !== 3'd0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL restart_edge16: got el=%0d done=%b expected el=0 done=0", Elapsed, Done);
        end
        cyc(1);
        total++;
        if (Elapsed !== 3'd1) begin
            bad++;
            $display("FAIL restart_edge17: got %0d expected 1", Elapsed);
        end
        cyc(2);
        Start = 1'b1;
        Stop = 1'b1;
        cyc(1);
        Start = 1'b0;
        Stop = 1'b0;
        total++;
        if (Running !== 1'b1 || Done !== 1'b0 || Elapsed !== 3'd0) begin
            bad++;
            $display("FAIL startstop: got run=%b done=%b el=%0d expected run=1 done=0 el=0", Running, Done, Elapsed);
        end
        cyc(4);
        total++;
        if (Elapsed !== 3'd1 || Running !== 1'b1) begin
            bad++;
            $display("FAIL startstop_tick: got el=%0d run=%b expected el=1 run=1", Elapsed, Running);
        end
        Stop = 1'b1;
        cyc(1);
        Stop = 1'b0;
        total++;
        if (Running !== 1'b0 || Done !== 1'b1) begin
            bad++;
            $display("FAIL startstop_end: got run=%b done=%b expected run=0 done=1", Running, Done);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_stop_on_tick();
        test_overflow();
        test_clear();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/elapsed_timer.md
# elapsed_timer

Cycle-accurate stopwatch that measures how long an event lasts, in prescaled ticks. It is the measuring counterpart of the fixed-delay countdown timer: the countdown waits a preset time, while this block reports how much time passed between Start and Stop. Game logic uses it for reaction and round timing, and the HUD display reads the held result.

## Interface
Parameters:
- TICK_CYCLES, default 50000: clock cycles per tick (1 ms at 50 MHz); must be ≥1.
- MAX_TICKS, default 65535: largest tick count representable; must be ≥1. W = $clog2(MAX_TICKS+1).

Ports:
- Clk  in  1  system clock; all logic on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  begin a new measurement (level sampled each edge).
- Stop  in  1  end the current measurement.
- Clear  in  1  synchronous return to IDLE with all results zeroed.
- Elapsed  out  W  ticks counted; frozen in HOLD.
- Running  out  1  high while in RUN.
- Done  out  1  one-cycle pulse on entry to HOLD.
- Overflow  out  1  sticky; measurement hit MAX_TICKS and was cut off.

## Operation
- States: IDLE, RUN, HOLD. Registered internal prescale counter, range 0..TICK_CYCLES-1.
- Control priority, per edge: Clear > Start > Stop.
- Clear (any state):
  - Next state IDLE.
  - Elapsed, prescale, Overflow and Done all 0.
- Start (any state, including RUN and HOLD):
  - Next state RUN.
  - Elapsed, prescale and Overflow set to 0.
  - Done 0. A restart never pulses Done.
- In RUN without Start or Clear:
  - The prescale counter increments each cycle.
  - A tick occurs in a cycle where prescale == TICK_CYCLES-1. The prescale counter then wraps to 0.
  - On a tick with Elapsed < MAX_TICKS: Elapsed increments.
  - On a tick with Elapsed == MAX_TICKS: Overflow is set, the state moves to HOLD, Done pulses, and Elapsed stays at MAX_TICKS.
  - Stop: the state moves to HOLD and Done pulses.
  - Stop and tick in the same cycle: the tick is discarded and Elapsed is not incremented.
- Stop in IDLE or HOLD: ignored.
- HOLD: Elapsed and Overflow are held until Start or Clear arrives.
- Running = (state == RUN), registered.
- Elapsed never wraps. The width W follows the parameter rule, with no truncation.

## Timing
- Reset_n low:
  - Takes effect immediately, without waiting for a clock edge, including mid-RUN.
  - The state becomes IDLE and the prescale counter is cleared.
  - Elapsed = 0, Running = 0, Done = 0, Overflow = 0.
- Release of Reset_n: the block is idle, and the first Start can be sampled on the next edge.
- Start sampled at edge k: Running = 1 after edge k, and prescale = 0.
- The first tick increments Elapsed at edge k+TICK_CYCLES. The n-th tick lands at edge k+n·TICK_CYCLES.
- TICK_CYCLES = 1: every RUN cycle after the Start edge is a tick.
- Stop sampled at edge s:
  - After edge s: Running = 0 and Done = 1.
  - After edge s+1: Done = 0.
  - Elapsed is stable from edge s onward.
- Overflow:
  - Overflow and Done rise at the edge of the (MAX_TICKS+1)-th tick, which is edge k+(MAX_TICKS+1)·TICK_CYCLES.
- Held Stop: Done still pulses only once. Stop must be deasserted and a new Start issued to rearm.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All cases use TICK_CYCLES = 4 and MAX_TICKS = 5 (W = 3).

1. Reset:
   - Stimulus: assert Reset_n = 0 between edges while in RUN with Elapsed = 2.
   - Required response: the outputs go to 0 immediately. After release, the block stays in IDLE with no activity until Start.
2. Basic measurement:
   - Stimulus: Start at edge 0, Stop at edge 10.
   - Required response: Elapsed = 1 at edge 4 and 2 at edge 8. Running falls after edge 10, and Done is high for exactly one cycle. Elapsed = 2 holds for 20 more cycles.
3. Stop coinciding with a tick:
   - Stimulus: Start at edge 0, Stop at edge 8.
   - Required response: Elapsed = 1 (tick suppressed), Done pulses, Overflow = 0.
4. Overflow:
   - Stimulus: Start at edge 0, never assert Stop.
   - Required response: Elapsed = 5 at edge 20. At edge 24, Overflow = 1, Done pulses, Running = 0, and Elapsed stays at 5. A later Stop has no effect.
5. Restart and priority:
   - Stimulus: Start at edge 0, then Start at edge 13 (Elapsed = 3).
   - Required response: Elapsed = 0 after edge 13 with no Done pulse, and the next increment is at edge 17.
   - Stimulus: Start and Stop together in one cycle.
   - Required response: Start wins and the block is in RUN.
6. Clear:
   - Stimulus: Clear in HOLD after an Overflow.
   - Required response: state IDLE, Elapsed = 0, Overflow = 0.
   - Stimulus: Clear and Start together.
   - Required response: IDLE and Running = 0.
